cascade_stage_ctrl: RTL and testbench

//  Stage sequencer for the cascade classifier: walks stages 0..N_STAGES-1 for one detection window.

---
 rtl/cascade_stage_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cascade_stage_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_stage_ctrl.sv
// -----------------------------------------------------------------------------
// cascade_stage_ctrl
//   Stage sequencer for the cascade classifier. For one detection window it
//   walks stages 0..N_STAGES-1. For each stage it reads the stage threshold
//   from the threshold ROM, accepts the accumulated stage sum from the feature
//   engine, and does a signed compare of the two. The window ends on the first
//   failing stage (reject) or after the last stage passes (detect).
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset (aborts a window, no result)
//   start          in   begin a window; only looked at while idle
//   busy           out  high whenever the sequencer is not idle
//   rom_en         out  ROM read enable, one cycle per stage
//   rom_addr       out  ROM address (= current stage)
//   rom_data       in   ROM read data, valid the cycle after rom_en
//   stage_idx      out  current stage, for the feature engine
//   sum_valid      in   stage sum valid
//   sum_data       in   signed accumulated stage sum
//   sum_ready      out  sequencer is accepting a stage sum
//   result_valid   out  one-cycle pulse at window end
//   result_detect  out  1 = all stages passed, 0 = rejected
//   result_stage   out  last stage evaluated
// -----------------------------------------------------------------------------
module cascade_stage_ctrl #(
  parameter int W_DATA   = 11,
  parameter int W_ADDR   = 5,
  parameter int N_STAGES = 25,
  parameter int W_SUM    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              rom_en,
  output logic [W_ADDR-1:0] rom_addr,
  input  logic [W_DATA-1:0] rom_data,
  output logic [W_ADDR-1:0] stage_idx,
  input  logic              sum_valid,
  input  logic [W_SUM-1:0]  sum_data,
  output logic              sum_ready,
  output logic              result_valid,
  output logic              result_detect,
  output logic [W_ADDR-1:0] result_stage
);

  localparam logic [W_ADDR-1:0] LAST_STAGE = W_ADDR'(N_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_LATCH    = 3'd2,
    S_WAIT_SUM = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                    state_q;
  logic [W_ADDR-1:0]         stage_q;
  logic signed [W_SUM-1:0]   thr_q;
  logic                      busy_q;
  logic                      rom_en_q;
  logic                      sum_ready_q;
  logic                      result_valid_q;
  logic                      result_detect_q;
  logic [W_ADDR-1:0]         result_stage_q;

  logic                      sum_xfer_s;
  logic                      stage_pass_s;

  // A transfer only happens while the sequencer advertises ready, so a
  // sum_valid seen in FETCH/LATCH is never consumed.
  assign sum_xfer_s   = sum_valid & sum_ready_q;
  // Full-width signed compare; equality counts as a pass.
  assign stage_pass_s = ($signed(sum_data) >= thr_q);

  // Sequencer FSM; every output is a register updated together with the state
  // so that it is valid for exactly the cycle the FSM spends in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      stage_q         <= {W_ADDR{1'b0}};
      thr_q           <= {W_SUM{1'b0}};
      busy_q          <= 1'b0;
      rom_en_q        <= 1'b0;
      sum_ready_q     <= 1'b0;
      result_valid_q  <= 1'b0;
      result_detect_q <= 1'b0;
      result_stage_q  <= {W_ADDR{1'b0}};
    end else begin
      // Single-cycle strobes default low.
      rom_en_q       <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            stage_q     <= {W_ADDR{1'b0}};
            state_q     <= S_FETCH;
            busy_q      <= 1'b1;
            rom_en_q    <= 1'b1;
          end else begin
            busy_q      <= 1'b0;
          end
          sum_ready_q   <= 1'b0;
        end
        S_FETCH: begin
          state_q       <= S_LATCH;
          sum_ready_q   <= 1'b0;
        end
        S_LATCH: begin
          // Signed size cast sign-extends the ROM threshold to the sum width.
          thr_q         <= W_SUM'($signed(rom_data));
          state_q       <= S_WAIT_SUM;
          sum_ready_q   <= 1'b1;
        end
        S_WAIT_SUM: begin
          if (sum_xfer_s) begin
            sum_ready_q <= 1'b0;
            if (!stage_pass_s) begin
              result_detect_q <= 1'b0;
              result_stage_q  <= stage_q;
              result_valid_q  <= 1'b1;
              state_q         <= S_DONE;
            end else if (stage_q == LAST_STAGE) begin
              // Last-stage check comes before any increment, so stage never wraps.
              result_detect_q <= 1'b1;
              result_stage_q  <= stage_q;
              result_valid_q  <= 1'b1;
              state_q         <= S_DONE;
            end else begin
              stage_q         <= stage_q + W_ADDR'(1'b1);
              rom_en_q        <= 1'b1;
              state_q         <= S_FETCH;
            end
          end else begin
            sum_ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
          sum_ready_q   <= 1'b0;
        end
        default: begin
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
          sum_ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign rom_en        = rom_en_q;
  assign rom_addr      = stage_q;
  assign stage_idx     = stage_q;
  assign sum_ready     = sum_ready_q;
  assign result_valid  = result_valid_q;
  assign result_detect = result_detect_q;
  assign result_stage  = result_stage_q;

endmodule

// File: tb/tb_cascade_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cascade_stage_ctrl
//   Scoreboard bench for cascade_stage_ctrl. The stimulus process loads a ROM
//   image and a per-stage list of sums, computes the expected window outcome
//   from the classification rule (first stage whose sum is below its threshold
//   rejects, otherwise detect at the last stage) and pushes it into a queue.
//   An independent environment process plays the ROM/feature engine, and pops
//   and checks every result pulse.
// -----------------------------------------------------------------------------
module tb_cascade_stage_ctrl;

  localparam int W_DATA   = 11;
  localparam int W_ADDR   = 5;
  localparam int N_STAGES = 25;
  localparam int W_SUM    = 18;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              rom_en;
  logic [W_ADDR-1:0] rom_addr;
  logic [W_DATA-1:0] rom_data;
  logic [W_ADDR-1:0] stage_idx;
  logic              sum_valid;
  logic [W_SUM-1:0]  sum_data;
  logic              sum_ready;
  logic              result_valid;
  logic              result_detect;
  logic [W_ADDR-1:0] result_stage;

  cascade_stage_ctrl #(
    .W_DATA(W_DATA), .W_ADDR(W_ADDR), .N_STAGES(N_STAGES), .W_SUM(W_SUM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .stage_idx(stage_idx), .sum_valid(sum_valid), .sum_data(sum_data),
    .sum_ready(sum_ready), .result_valid(result_valid),
    .result_detect(result_detect), .result_stage(result_stage)
  );

  typedef struct {
    logic   det;
    int     stg;
    int     lat;        // -1 = latency not checked
    longint start_cyc;
  } exp_t;

  exp_t             sb[$];
  logic [W_DATA-1:0] rom     [0:31];
  logic [W_SUM-1:0]  cur_sum [0:31];
  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     xfer_cnt = 0;
  int     fetch_cnt = 0;
  int     hold_at = -1;
  bit     stall_mode = 1'b0;
  bit     prev_rv = 1'b0;
  bit     prev_rom_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read threshold ROM: data appears the cycle after rom_en.
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference rule: the window rejects at the first stage whose sum is below
  // its threshold; if none does, it detects at the last stage.
  function automatic void ref_model(output logic det, output int stg);
    det = 1'b1;
    stg = N_STAGES - 1;
    for (int i = 0; i < N_STAGES; i++) begin
      if (int'($signed(cur_sum[i])) < int'($signed(rom[i]))) begin
        det = 1'b0;
        stg = i;
        return;
      end
    end
  endfunction

  // Environment: feature-engine driver plus result/ROM-address monitor.
  always @(negedge clk) begin
    if (rst) begin
      xfer_cnt    = 0;
      fetch_cnt   = 0;
      prev_rv     = 1'b0;
      prev_rom_en = 1'b0;
      sum_valid   = 1'b0;
    end else begin
      if (prev_rv) chk("busy_idle_after_done", busy, 0);
      if (rom_en) begin
        chk("rom_addr", rom_addr, fetch_cnt);
        chk("stage_idx_fetch", stage_idx, fetch_cnt);
        chk("rom_en_single", prev_rom_en, 0);
        fetch_cnt++;
      end
      if (result_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result_detect", result_detect, e.det);
          chk("result_stage", result_stage, e.stg);
          chk("fetch_count", fetch_cnt, e.stg + 1);
          chk("xfer_count", xfer_cnt, e.stg + 1);
          chk("busy_done", busy, 1);
          if (e.lat >= 0) chk("latency", cyc - e.start_cyc + 1, e.lat);
        end
        xfer_cnt  = 0;
        fetch_cnt = 0;
      end
      prev_rv     = result_valid;
      prev_rom_en = rom_en;

      if (xfer_cnt == hold_at)  sum_valid = 1'b0;
      else if (stall_mode)      sum_valid = ($urandom_range(0, 2) != 0);
      else                      sum_valid = 1'b1;
      sum_data = (xfer_cnt < 32) ? cur_sum[xfer_cnt] : W_SUM'($urandom);
      if (sum_valid && sum_ready) begin
        chk("stage_idx_xfer", stage_idx, xfer_cnt);
        xfer_cnt++;
      end
    end
  end

  task automatic run_window(input bit lat_check);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    ref_model(e.det, e.stg);
    e.lat       = lat_check ? (1 + 3 * (e.stg + 1) + 1) : -1;
    e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_stage(input int s, input string name);
    bit got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sum_ready && (int'(stage_idx) == s)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(name, 0, 1);
  endtask

  task automatic fill_pass(input int sum_val);
    for (int i = 0; i < 32; i++) begin
      rom[i]     = W_DATA'($urandom_range(0, 2024) - 1024);
      cur_sum[i] = W_SUM'(sum_val);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sum_valid = 1'b0;
    sum_data = '0;
    for (int i = 0; i < 32; i++) begin
      rom[i] = '0;
      cur_sum[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_sum_ready", sum_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_detect", result_detect, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_stage_idx", stage_idx, 0);
    chk("rst_result_stage", result_stage, 0);
    rst = 1'b0;

    // Immediate reject at stage 0.
    fill_pass(1000);
    rom[0] = 11'h5FE;
    cur_sum[0] = W_SUM'(-515);
    run_window(1'b1);
    wait_done();

    // Equality passes, reject at stage 1 (back-to-back with the previous).
    rom[0] = W_DATA'(-514);
    rom[1] = W_DATA'(-508);
    cur_sum[0] = W_SUM'(-514);
    cur_sum[1] = W_SUM'(-509);
    run_window(1'b1);
    wait_done();

    // Full detect, sum always valid: 77 cycles start to result.
    fill_pass(1000);
    run_window(1'b1);
    wait_done();

    // Back-to-back full detect restarts at stage 0 in the IDLE cycle after DONE.
    run_window(1'b1);
    wait_done();

    // Stall at stage 2 for 10 cycles, with an ignored start pulse.
    fill_pass(1023);
    hold_at = 2;
    run_window(1'b0);
    wait_stage(2, "reach_stage2");
    for (int k = 0; k < 10; k++) begin
      chk("stall_sum_ready", sum_ready, 1);
      chk("stall_stage", stage_idx, 2);
      chk("stall_busy", busy, 1);
      chk("stall_rom_en", rom_en, 0);
      start = (k == 3);
      @(negedge clk);
    end
    start = 1'b0;
    hold_at = -1;
    wait_done();

    // Reset mid-WAIT_SUM at stage 3: window aborted, no result pulse.
    repeat (2) @(negedge clk);
    fill_pass(1023);
    hold_at = 3;
    run_window(1'b0);
    wait_stage(3, "reach_stage3");
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rom_en", rom_en, 0);
    chk("abort_sum_ready", sum_ready, 0);
    chk("abort_stage_idx", stage_idx, 0);
    chk("abort_result_valid", result_valid, 0);
    @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    hold_at = -1;
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized windows, some with random sum_valid stalls.
    for (int w = 0; w < 40; w++) begin
      bit all_pass = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 32; i++) begin
        int ti;
        int s;
        int r;
        rom[i] = W_DATA'($urandom_range(0, 2047));
        ti = int'($signed(rom[i]));
        r  = all_pass ? int'($urandom_range(3, 9)) : int'($urandom_range(0, 13));
        case (r)
          0:       s = ti - 1 - int'($urandom_range(0, 30));
          1:       s = ti;
          2:       s = int'($urandom_range(0, 262143)) - 131072;
          default: s = ti + int'($urandom_range(0, 30));
        endcase
        cur_sum[i] = W_SUM'(s);
      end
      stall_mode = ($urandom_range(0, 2) == 0);
      run_window(!stall_mode);
      wait_done();
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    stall_mode = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
